// File: rtl/bit_serial_adder_ctrl.sv
// rtl/bit_serial_adder_ctrl.sv - WIDTH-bit adder built from one full-adder cell, one bit per clock, LSB first.
// Optional ADDSUB_EN adds a Sub input that turns the operation into A-B.
module bit_serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef ADDSUB_EN
  input  logic             Sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] load_b;
  logic             load_c;
  logic             last_bit;

  // Subtract is add of the inverted operand with a forced carry-in of one.
`ifdef ADDSUB_EN
  assign load_b = Sub ? ~B : B;
  assign load_c = Sub ? 1'b1 : Cin;
`else
  assign load_b = B;
  assign load_c = Cin;
`endif

  assign fa_s     = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_co    = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry);
  assign last_bit = (cnt == LAST_BIT);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr  <= A;
            b_sr  <= load_b;
            carry <= load_c;
            cnt   <= '0;
          end
        end
        RUN: begin
          sum_q <= {fa_s, sum_q[WIDTH-1:1]};
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          carry <= fa_co;
          // Counter parks on the last index instead of wrapping.
          if (last_bit) begin
            cout_q <= fa_co;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;

endmodule
